// File: rtl/glyph_address_gen.sv
// Sequential flash glyph bit-address generator built around one shared restoring divider.
// Define GLYPH_ADDR_ERR_EN to add the degenerate-request flag on port err.
module glyph_address_gen #(
    parameter int memFontHeight     = 128,
    parameter int memFontWidth      = 64,
    parameter int charactersPerFont = 256,
    parameter int COORD_W           = 16,
    parameter int ADDR_W            = 30
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               in_valid,
    output logic               in_ready,
    input  logic [COORD_W-1:0] drawnFontWidth,
    input  logic [COORD_W-1:0] drawnFontHeight,
    input  logic [COORD_W-1:0] layerX,
    input  logic [COORD_W-1:0] layerY,
    input  logic [COORD_W-1:0] fontSelectionIndex,
    input  logic [COORD_W-1:0] characterIndex,
    output logic               out_valid,
    input  logic               out_ready,
`ifdef GLYPH_ADDR_ERR_EN
    output logic               err,
`endif
    output logic [ADDR_W-1:0]  addressOffsetBits
);

    localparam int BW     = $clog2(memFontWidth);
    localparam int BH     = $clog2(memFontHeight);
    localparam int BC     = $clog2(charactersPerFont);
    localparam int DIVW   = COORD_W + ((BW > BH) ? BW : BH);
    localparam int CNT_W  = $clog2(DIVW + 1);
    localparam int FULL_W = COORD_W + BC + BH + BW;

    localparam logic [CNT_W-1:0]   LAST_STEP = CNT_W'(DIVW);
    localparam logic [DIVW-1:0]    MEM_W_M1  = DIVW'(memFontWidth - 1);
    localparam logic [DIVW-1:0]    MEM_H_M1  = DIVW'(memFontHeight - 1);
    localparam logic [COORD_W-1:0] SIZE_ONE  = COORD_W'(1);
    localparam logic [COORD_W-1:0] SIZE_MIN  = COORD_W'(2);

    typedef enum logic [2:0] {
        IDLE,
        XMOD,
        XSCL,
        YMOD,
        YSCL,
        DONE
    } state_e;

    state_e             state_q;
    logic [CNT_W-1:0]   cnt_q;
    logic [COORD_W-1:0] w_q;
    logic [COORD_W-1:0] h_q;
    logic [COORD_W-1:0] x_q;
    logic [COORD_W-1:0] y_q;
    logic [COORD_W-1:0] font_q;
    logic [BC-1:0]      char_q;
    logic [BW-1:0]      col_q;
    logic [DIVW-1:0]    rem_q;
    logic [DIVW-1:0]    quo_q;
    logic [DIVW-1:0]    dvs_q;
    logic [ADDR_W-1:0]  addr_q;
    logic               out_valid_q;

    logic [DIVW:0]      rem_shift;
    logic [DIVW:0]      rem_diff;
    logic [DIVW-1:0]    step_rem_d;
    logic [DIVW-1:0]    step_quo_d;
    logic [COORD_W-1:0] w_m1;
    logic [COORD_W-1:0] h_m1;
    logic [BW-1:0]      col_d;
    logic [BH-1:0]      row_d;
    logic [FULL_W-1:0]  full_addr;
    logic               accept;

    // One restoring-division step: the dividend shifts out of quo_q into the remainder
    // while quotient bits shift in from the bottom.
    always_comb begin
        // NOTE: every output of this block is assigned on every path, so no latch is inferred.
        rem_shift = {rem_q, quo_q[DIVW-1]};
        rem_diff  = rem_shift - {1'b0, dvs_q};
        if (rem_diff[DIVW]) begin
            step_rem_d = rem_shift[DIVW-1:0];
            step_quo_d = {quo_q[DIVW-2:0], 1'b0};
        end else begin
            step_rem_d = rem_diff[DIVW-1:0];
            step_quo_d = {quo_q[DIVW-2:0], 1'b1};
        end
    end

    assign w_m1      = w_q - SIZE_ONE;
    assign h_m1      = h_q - SIZE_ONE;
    // Sizes below 2 make the scaling divide by zero; that quotient is thrown away.
    assign col_d     = (w_q < SIZE_MIN) ? '0 : step_quo_d[BW-1:0];
    assign row_d     = (h_q < SIZE_MIN) ? '0 : step_quo_d[BH-1:0];
    assign full_addr = {font_q, char_q, row_d, col_q};

    // in_ready looks through to out_ready so DONE can retire and accept on one edge.
    assign in_ready  = (state_q == IDLE) || ((state_q == DONE) && out_ready);
    assign accept    = in_valid && in_ready;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            // NOTE: the datapath is reset as well, so an aborted request leaves nothing stale behind.
            state_q     <= IDLE;
            cnt_q       <= '0;
            w_q         <= '0;
            h_q         <= '0;
            x_q         <= '0;
            y_q         <= '0;
            font_q      <= '0;
            char_q      <= '0;
            col_q       <= '0;
            rem_q       <= '0;
            quo_q       <= '0;
            dvs_q       <= '0;
            addr_q      <= '0;
            out_valid_q <= 1'b0;
        end else begin
            if (accept) begin
                w_q    <= drawnFontWidth;
                h_q    <= drawnFontHeight;
                x_q    <= layerX;
                y_q    <= layerY;
                font_q <= fontSelectionIndex;
                char_q <= characterIndex[BC-1:0];
            end
            case (state_q)
                IDLE: begin
                    if (accept) begin
                        state_q <= XMOD;
                        cnt_q   <= '0;
                    end
                end
                DONE: begin
                    if (out_ready) begin
                        out_valid_q <= 1'b0;
                        state_q     <= accept ? XMOD : IDLE;
                        cnt_q       <= '0;
                    end
                end
                default: begin
                    // The first XMOD cycle loads the divider from the captured request.
                    if ((state_q == XMOD) && (cnt_q == '0)) begin
                        rem_q <= '0;
                        quo_q <= DIVW'(x_q);
                        dvs_q <= DIVW'(w_q);
                        cnt_q <= CNT_W'(1);
                    end else if (cnt_q != LAST_STEP) begin
                        rem_q <= step_rem_d;
                        quo_q <= step_quo_d;
                        cnt_q <= cnt_q + CNT_W'(1);
                    end else begin
                        rem_q <= '0;
                        case (state_q)
                            XMOD: begin
                                quo_q   <= step_rem_d * MEM_W_M1;
                                dvs_q   <= DIVW'(w_m1);
                                cnt_q   <= CNT_W'(1);
                                state_q <= XSCL;
                            end
                            XSCL: begin
                                col_q   <= col_d;
                                quo_q   <= DIVW'(y_q);
                                dvs_q   <= DIVW'(h_q);
                                cnt_q   <= CNT_W'(1);
                                state_q <= YMOD;
                            end
                            YMOD: begin
                                quo_q   <= step_rem_d * MEM_H_M1;
                                dvs_q   <= DIVW'(h_m1);
                                cnt_q   <= CNT_W'(1);
                                state_q <= YSCL;
                            end
                            default: begin
                                // Fields never overlap, so the sum is a plain concatenation.
                                addr_q      <= ADDR_W'(full_addr);
                                out_valid_q <= 1'b1;
                                cnt_q       <= '0;
                                state_q     <= DONE;
                            end
                        endcase
                    end
                end
            endcase
        end
    end

    assign out_valid         = out_valid_q;
    assign addressOffsetBits = addr_q;

`ifdef GLYPH_ADDR_ERR_EN
    logic err_pend_q;
    logic err_q;
    logic req_degen;

    assign req_degen = (drawnFontWidth < SIZE_MIN) || (drawnFontHeight < SIZE_MIN) ||
                       (|characterIndex[COORD_W-1:BC]);

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            err_pend_q <= 1'b0;
            err_q      <= 1'b0;
        end else begin
            if (accept) begin
                err_pend_q <= req_degen;
            end
            if ((state_q == YSCL) && (cnt_q == LAST_STEP)) begin
                err_q <= err_pend_q;
            end else if ((state_q == DONE) && out_ready) begin
                err_q <= 1'b0;
            end
        end
    end

    assign err = err_q;
`else
    logic unused_char_hi;
    assign unused_char_hi = ^characterIndex[COORD_W-1:BC];
`endif

endmodule

// File: tb/tb_glyph_address_gen.sv
// Scoreboard bench for glyph_address_gen: the driver queues hand-computed results on accept,
// a negedge monitor checks latency, address and (with GLYPH_ADDR_ERR_EN) err at each handshake.
module tb_glyph_address_gen;

    localparam int COORD_W = 16;
    localparam int ADDR_W  = 30;
    localparam int LATENCY = 93;

    typedef struct {
        logic [ADDR_W-1:0] addr;
        logic              err;
        int                acc_cyc;
    } exp_t;

    exp_t sb_q[$];
    exp_t mon_e;

    logic               clk = 1'b0;
    logic               rst;
    logic               in_valid;
    logic               in_ready;
    logic [COORD_W-1:0] drawnFontWidth;
    logic [COORD_W-1:0] drawnFontHeight;
    logic [COORD_W-1:0] layerX;
    logic [COORD_W-1:0] layerY;
    logic [COORD_W-1:0] fontSelectionIndex;
    logic [COORD_W-1:0] characterIndex;
    logic               out_valid;
    logic               out_ready;
    logic [ADDR_W-1:0]  addressOffsetBits;
`ifdef GLYPH_ADDR_ERR_EN
    logic               err;
`endif

    int cyc      = 0;
    int checks   = 0;
    int failures = 0;
    logic prev_valid = 1'b0;

    glyph_address_gen dut (
        .clk                (clk),
        .rst                (rst),
        .in_valid           (in_valid),
        .in_ready           (in_ready),
        .drawnFontWidth     (drawnFontWidth),
        .drawnFontHeight    (drawnFontHeight),
        .layerX             (layerX),
        .layerY             (layerY),
        .fontSelectionIndex (fontSelectionIndex),
        .characterIndex     (characterIndex),
        .out_valid          (out_valid),
        .out_ready          (out_ready),
`ifdef GLYPH_ADDR_ERR_EN
        .err                (err),
`endif
        .addressOffsetBits  (addressOffsetBits)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc++;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %0d expected %0d (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // Monitor: latency on each rising out_valid, payload on each output handshake.
    always @(negedge clk) begin
        if (rst && out_valid && !prev_valid) begin
            if (sb_q.size() == 0) check("unexpected_result", out_valid, 1'b0);
            else                  check("latency", cyc - sb_q[0].acc_cyc, LATENCY);
        end
        if (rst && out_valid && out_ready && (sb_q.size() != 0)) begin
            mon_e = sb_q.pop_front();
            check("addr", addressOffsetBits, mon_e.addr);
`ifdef GLYPH_ADDR_ERR_EN
            check("err", err, mon_e.err);
`endif
        end
        prev_valid = rst && out_valid;
    end

    // Called just after a rising edge; returns just after the accepting edge.
    task automatic send(input logic [15:0] w, input logic [15:0] h, input logic [15:0] x,
                        input logic [15:0] y, input logic [15:0] f, input logic [15:0] c,
                        input logic [ADDR_W-1:0] exp_addr, input logic exp_err);
        int n;
        drawnFontWidth     = w;
        drawnFontHeight    = h;
        layerX             = x;
        layerY             = y;
        fontSelectionIndex = f;
        characterIndex     = c;
        in_valid           = 1'b1;
        n = 0;
        @(negedge clk);
        while (!in_ready && n < 300) begin
            n++;
            @(negedge clk);
        end
        if (!in_ready) begin
            check("accept_timeout", in_ready, 1'b1);
            in_valid = 1'b0;
            return;
        end
        @(posedge clk);
        #1;
        sb_q.push_back('{exp_addr, exp_err, cyc});
        in_valid           = 1'b0;
        drawnFontWidth     = 16'hFFFF;
        drawnFontHeight    = 16'hFFFF;
        layerX             = 16'hFFFF;
        layerY             = 16'hFFFF;
        fontSelectionIndex = 16'hFFFF;
        characterIndex     = 16'hFFFF;
    endtask

    task automatic wait_drain();
        int n = 0;
        while (sb_q.size() != 0 && n < 400) begin
            @(negedge clk);
            n++;
        end
        check("drain_timeout", sb_q.size(), 0);
        @(posedge clk);
        #1;
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1);
    end

    initial begin
        int n;
        rst = 1'b0; in_valid = 1'b0; out_ready = 1'b0;
        drawnFontWidth = '0; drawnFontHeight = '0; layerX = '0; layerY = '0;
        fontSelectionIndex = '0; characterIndex = '0;
        #1;
        check("reset_in_ready", in_ready, 1'b1);
        check("reset_out_valid", out_valid, 1'b0);
        check("reset_addr", addressOffsetBits, 0);
`ifdef GLYPH_ADDR_ERR_EN
        check("reset_err", err, 1'b0);
`endif
        repeat (3) @(posedge clk);
        #2 rst = 1'b1;
        @(posedge clk);
        #1;
        out_ready = 1'b1;

        // Normal request, with a stray in_valid during the computation that must be ignored.
        send(16, 32, 37, 45, 1, 65, 30'd2633045, 1'b0);
        in_valid = 1'b1;
        repeat (5) begin
            @(negedge clk);
            check("busy_in_ready", in_ready, 1'b0);
        end
        in_valid = 1'b0;
        wait_drain();

        send(16, 32, 15, 31, 0, 0,   30'd8191,   1'b0);  // corner pixel
        wait_drain();
        send(1,  0,  9,  9,  0, 2,   30'd16384,  1'b1);  // degenerate sizes
        wait_drain();
        send(16, 16, 0,  0,  0, 300, 30'd360448, 1'b1);  // character index overflow
        wait_drain();

        // Back-to-back: second request is accepted on the edge the first result retires.
        send(8,  8,  100, 3, 2,   255, 30'd6286756, 1'b0);
        send(16, 16, 0,   0, 513, 0,   30'd2097152, 1'b0);  // font bits above ADDR_W dropped
        wait_drain();

        // Backpressure.
        out_ready = 1'b0;
        send(16, 32, 15, 31, 0, 0, 30'd8191, 1'b0);
        n = 0;
        do begin
            @(negedge clk);
            n++;
        end while (!out_valid && n < 200);
        check("bp_valid_rise", out_valid, 1'b1);
        repeat (10) begin
            @(negedge clk);
            check("bp_hold_valid", out_valid, 1'b1);
            check("bp_hold_addr", addressOffsetBits, 30'd8191);
            check("bp_hold_in_ready", in_ready, 1'b0);
        end
        @(posedge clk);
        #1;
        out_ready = 1'b1;
        send(16, 32, 37, 45, 1, 65, 30'd2633045, 1'b0);
        @(negedge clk);
        check("bp_retired_valid", out_valid, 1'b0);
        check("bp_next_busy", in_ready, 1'b0);
        wait_drain();

        // Reset in the middle of YMOD.
        send(16, 32, 37, 45, 1, 65, 30'd2633045, 1'b0);
        repeat (50) @(posedge clk);
        #2 rst = 1'b0;
        #1;
        check("midrst_out_valid", out_valid, 1'b0);
        check("midrst_in_ready", in_ready, 1'b1);
        check("midrst_addr", addressOffsetBits, 0);
        sb_q.delete();
        repeat (2) @(posedge clk);
        #2 rst = 1'b1;
        @(negedge clk);
        check("post_rst_out_valid", out_valid, 1'b0);
        check("post_rst_in_ready", in_ready, 1'b1);
        repeat (120) @(posedge clk);
        #1;
        check("no_stray_result", out_valid, 1'b0);
        send(16, 32, 15, 31, 0, 0, 30'd8191, 1'b0);
        wait_drain();

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
